// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage CPU pipeline control:
//   REG_AW    - register-file address width
//   NOP_INSTR - encoding a flushed or bubbled pipeline register carries
//   state_e   - pipeline sequencer state encoding (RUN=0, MEMWAIT=1)
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned REG_AW    = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard/sequencer block.
//   master : pipeline side. It drives the decode, EX and MEM stage status and
//            the memory ack, and receives the control outputs.
//   slave  : hazard_ctrl side.
// Decode/EX/MEM status : ID_rA, ID_rB, ID_srcA_vld, ID_srcB_vld, ID_is_br,
//                        ID_br_ctrl, EX_rD, EX_wrEn, EX_memEn, MEM_memEn, mem_ack
// Controls             : mem_req, PC_wrEn, IF_ID_wrEn, IF_ID_flush,
//                        ID_EX_bubble, pipe_freeze, mem_timeout, stall_cycles
// ----------------------------------------------------------------------------
interface hazard_ctrl_if
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = cpu_pkg::REG_AW,
    parameter int unsigned CNT_W  = 16
);

    logic [REG_AW-1:0] ID_rA;
    logic [REG_AW-1:0] ID_rB;
    logic              ID_srcA_vld;
    logic              ID_srcB_vld;
    logic              ID_is_br;
    logic              ID_br_ctrl;
    logic [REG_AW-1:0] EX_rD;
    logic              EX_wrEn;
    logic              EX_memEn;
    logic              MEM_memEn;
    logic              mem_ack;

    logic              mem_req;
    logic              PC_wrEn;
    logic              IF_ID_wrEn;
    logic              IF_ID_flush;
    logic              ID_EX_bubble;
    logic              pipe_freeze;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output ID_rA, ID_rB, ID_srcA_vld, ID_srcB_vld, ID_is_br, ID_br_ctrl,
               EX_rD, EX_wrEn, EX_memEn, MEM_memEn, mem_ack,
        input  mem_req, PC_wrEn, IF_ID_wrEn, IF_ID_flush, ID_EX_bubble,
               pipe_freeze, mem_timeout, stall_cycles
    );

    modport slave (
        input  ID_rA, ID_rB, ID_srcA_vld, ID_srcB_vld, ID_is_br, ID_br_ctrl,
               EX_rD, EX_wrEn, EX_memEn, MEM_memEn, mem_ack,
        output mem_req, PC_wrEn, IF_ID_wrEn, IF_ID_flush, ID_EX_bubble,
               pipe_freeze, mem_timeout, stall_cycles
    );

endinterface

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on a MEM-stage access and abandons it after
// MAX_WAIT cycles with a sticky timeout flag.
//   clk, reset     : clock, synchronous active-high reset
//   i_start        : access missed its first cycle. The count loads 1.
//   i_in_wait      : sequencer is in MEMWAIT
//   i_ack          : memory completes the access this cycle
//   o_hold_c       : keep the pipeline frozen this cycle (combinational)
//   o_mem_timeout  : sticky, set when an access is abandoned
// ----------------------------------------------------------------------------
module mem_wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_in_wait,
    input  logic i_ack,
    output logic o_hold_c,
    output logic o_mem_timeout
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;
    logic              w_below_max;
    logic              w_expire;

    assign w_below_max = (r_wait_cnt < WAIT_W'(MAX_WAIT));
    assign o_hold_c    = i_in_wait & ~i_ack & w_below_max;
    // An ack that arrives on the last allowed cycle still completes the access.
    assign w_expire    = i_in_wait & ~i_ack & ~w_below_max;

    // Wait counter. It is held at zero outside MEMWAIT, and increments are bounded by w_below_max.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_expire) begin
                r_mem_timeout <= 1'b1;
            end
            if (i_start) begin
                r_wait_cnt <= WAIT_W'(1);
            end else if (o_hold_c) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign o_mem_timeout = r_mem_timeout;

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencer for the 5-stage CPU. It sits beside ID and does three things:
//   - It detects load-use and branch-operand hazards. On a hazard it stalls PC and
//     IF/ID and bubbles ID/EX.
//   - It freezes the whole pipeline while a MEM-stage access waits on memory.
//   - It flushes IF/ID on a taken branch resolved in ID.
// Priority is freeze > hazard > flush. The mem_timeout and stall_cycles outputs
// are registered. The other controls are decoded combinationally from the state
// and the inputs.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_ctrl_if.slave (stage status in, pipeline controls out)
// ----------------------------------------------------------------------------
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW   = cpu_pkg::REG_AW,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic [REG_AW-1:0] w_id_ra;
    logic [REG_AW-1:0] w_id_rb;
    logic [REG_AW-1:0] w_ex_rd;
    logic              w_ld_use;
    logic              w_br_dep;
    logic              w_hz;
    logic              w_freeze;
    logic              w_hold_c;
    logic              w_start;
    logic              w_in_wait;
    logic              w_mem_timeout;

    logic              w_pc_wren;
    logic              w_if_id_wren;
    logic              w_if_id_flush;
    logic              w_id_ex_bubble;
    logic              w_pipe_freeze;
    logic              w_mem_req;

    assign w_id_ra = bus.ID_rA;
    assign w_id_rb = bus.ID_rB;
    assign w_ex_rd = bus.EX_rD;

    // A missing ack freezes the pipe. In RUN that is on the first cycle of the access.
    // In MEMWAIT the timer decides until the access completes or is abandoned.
    assign w_in_wait = (r_state == MEMWAIT);
    assign w_freeze  = w_in_wait ? w_hold_c : (bus.MEM_memEn & ~bus.mem_ack);
    assign w_start   = ~w_in_wait & w_freeze;

    // R0 is compared like any other register.
    assign w_ld_use = bus.EX_memEn & bus.EX_wrEn &
                      ((bus.ID_srcA_vld & (w_ex_rd == w_id_ra)) |
                       (bus.ID_srcB_vld & (w_ex_rd == w_id_rb)));
    assign w_br_dep = bus.ID_is_br & bus.ID_srcB_vld & bus.EX_wrEn & (w_ex_rd == w_id_rb);

    // The hazard is also checked on the cycle a MEMWAIT releases, because ID/EX advances on that cycle.
    assign w_hz = ~w_freeze & (w_ld_use | w_br_dep);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_mem_wait_timer (
        .clk           (clk),
        .reset         (reset),
        .i_start       (w_start),
        .i_in_wait     (w_in_wait),
        .i_ack         (bus.mem_ack),
        .o_hold_c      (w_hold_c),
        .o_mem_timeout (w_mem_timeout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control decode
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_wren      = 1'b1;
        w_if_id_wren   = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_pipe_freeze  = 1'b0;
        w_mem_req      = bus.MEM_memEn;

        case (r_state)
            RUN:     if (w_freeze)  w_state_nxt = MEMWAIT;
            MEMWAIT: if (!w_freeze) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase

        if (reset) begin
            w_pc_wren      = 1'b0;
            w_if_id_wren   = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_mem_req      = 1'b0;
        end else if (w_freeze) begin
            w_pc_wren      = 1'b0;
            w_if_id_wren   = 1'b0;
            w_pipe_freeze  = 1'b1;
        end else if (w_hz) begin
            w_pc_wren      = 1'b0;
            w_if_id_wren   = 1'b0;
            w_id_ex_bubble = 1'b1;
        end else if (bus.ID_br_ctrl) begin
            // PC loads the branch target and IF/ID loads a NOP in place of the wrong-path fetch.
            w_if_id_flush  = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_wren && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.PC_wrEn      = w_pc_wren;
    assign bus.IF_ID_wrEn   = w_if_id_wren;
    assign bus.IF_ID_flush  = w_if_id_flush;
    assign bus.ID_EX_bubble = w_id_ex_bubble;
    assign bus.pipe_freeze  = w_pipe_freeze;
    assign bus.mem_timeout  = w_mem_timeout;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
